// File: rtl/ext_stage.sv
// Immediate extension stage: zero/sign/upper/branch extension of a raw immediate, carried with a sideband tag.
// Latency: 1 cycle from acceptance to out_valid. Results are computed at acceptance and held in registers.
// Backpressure: a two-entry skid buffer (main + skid). in_ready is registered and drops only when both entries are full.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   flush                 discards every buffered item; overrides both handshakes in the same cycle
//   in_valid/in_ready     input handshake; in_imm[IN_W], in_op[3], in_tag[TAG_W]
//   out_valid/out_ready   output handshake; out_imm[OUT_W], out_tag[TAG_W], driven straight from the main entry
//
// Build option: define EXT_BRANCH_EN to enable mode 3 (BRANCH: sign-extend then shift left by 2).
//   Without it, mode 3 returns zero like modes 4-7 and no shifter is built.
//   OUT_W must be greater than IN_W.

module ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef struct packed {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nstate;
  logic   r_in_ready;
  logic   r_out_valid;
  ent_t   r_main;
  ent_t   r_skid;

  logic   w_acc;
  logic   w_dlv;
  logic   w_ld_main_in;
  logic   w_ld_main_skid;
  logic   w_ld_skid_in;

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_lui;
  logic [OUT_W-1:0] w_ext;
  ent_t             w_ext_ent;

  // ---------------------------------------------------------------------------
  // Extension datapath (evaluated on the incoming item only)
  // ---------------------------------------------------------------------------
  assign w_zext = {{PAD_W{1'b0}}, in_imm};
  assign w_sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
  assign w_lui  = {in_imm, {PAD_W{1'b0}}};

  always_comb begin
    w_ext = '0;
    case (in_op)
      3'd0:    w_ext = w_zext;
      3'd1:    w_ext = w_sext;
      3'd2:    w_ext = w_lui;
`ifdef EXT_BRANCH_EN
      // Upper bits shifted out are simply dropped.
      3'd3:    w_ext = w_sext << 2;
`endif
      default: w_ext = '0;
    endcase
  end

  assign w_ext_ent = '{imm: w_ext, tag: in_tag};

  // Flush kills both handshakes so nothing is accepted or delivered that cycle.
  assign w_acc = in_valid && r_in_ready && !flush;
  assign w_dlv = r_out_valid && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // in_ready / out_valid are registered copies of the next-state decode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_in_ready  <= (w_nstate != S_FULL);
      r_out_valid <= (w_nstate != S_EMPTY);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nstate = r_state;
    if (flush) begin
      w_nstate = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_acc) w_nstate = S_ONE;
        S_ONE: begin
          if (w_acc && !w_dlv)      w_nstate = S_FULL;
          else if (!w_acc && w_dlv) w_nstate = S_EMPTY;
        end
        S_FULL:  if (w_dlv) w_nstate = S_ONE;
        default: w_nstate = S_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: entry load controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid_in   = 1'b0;
    case (r_state)
      S_EMPTY: w_ld_main_in = w_acc;
      S_ONE: begin
        // Simultaneous accept+deliver replaces main directly; the skid stays idle.
        w_ld_main_in = w_acc && w_dlv;
        w_ld_skid_in = w_acc && !w_dlv;
      end
      S_FULL:  w_ld_main_skid = w_dlv;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage. Main holds its value whenever no load fires, which keeps
  // out_imm/out_tag stable across a stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= w_ext_ent;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid_in)        r_skid <= w_ext_ent;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_imm   = r_main.imm;
  assign out_tag   = r_main.tag;

endmodule

// File: tb/tb_ext_stage.sv
module tb_ext_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_tag;

  // Narrow instance (IN_W=8, OUT_W=16)
  logic        n_flush;
  logic        n_in_valid;
  logic        n_in_ready;
  logic [7:0]  n_in_imm;
  logic [2:0]  n_in_op;
  logic [4:0]  n_in_tag;
  logic        n_out_valid;
  logic        n_out_ready;
  logic [15:0] n_out_imm;
  logic [4:0]  n_out_tag;

  int n_err = 0;
  int n_chk = 0;

`ifdef EXT_BRANCH_EN
  localparam logic [31:0] EXP_BR_FFFF = 32'hFFFFFFFC;
  localparam logic [31:0] EXP_BR_0001 = 32'h00000004;
  localparam logic [15:0] EXP_NBR_FF  = 16'hFFFC;
`else
  localparam logic [31:0] EXP_BR_FFFF = 32'h00000000;
  localparam logic [31:0] EXP_BR_0001 = 32'h00000000;
  localparam logic [15:0] EXP_NBR_FF  = 16'h0000;
`endif

  always #5 clk = ~clk;

  ext_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
  );

  ext_stage #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut_n (
    .clk(clk), .rst(rst), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_imm(n_in_imm), .in_op(n_in_op), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_imm(n_out_imm), .out_tag(n_out_tag)
  );

  // Reference extension computed with integer arithmetic on the immediate's numeric value.
  function automatic logic [31:0] ext_model(input int unsigned imm, input int op, input int iw, input int ow);
    longint lim_in, lim_out, sval, r;
    lim_in  = longint'(1) << iw;
    lim_out = longint'(1) << ow;
    sval    = (longint'(imm) >= lim_in / 2) ? longint'(imm) - lim_in : longint'(imm);
    case (op)
      0: r = longint'(imm);
      1: r = (sval + lim_out) % lim_out;
      2: r = longint'(imm) * (lim_out / lim_in);
      3: begin
`ifdef EXT_BRANCH_EN
        r = ((sval * 4) % lim_out + lim_out) % lim_out;
`else
        r = 0;
`endif
      end
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
  } item_t;

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_imm = 16'h1234; in_op = 3'd1; in_tag = 5'd9; out_ready = 1'b0;
    n_flush = 1'b0; n_in_valid = 1'b1; n_in_imm = 8'h55; n_in_op = 3'd0; n_in_tag = 5'd3; n_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_chk++; if (out_imm !== 32'h0) begin n_err++; $display("FAIL reset_out_imm: got %h expected 00000000", out_imm); end
    n_chk++; if (out_tag !== 5'h0) begin n_err++; $display("FAIL reset_out_tag: got %h expected 00", out_tag); end
    n_chk++; if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1 || n_out_imm !== 16'h0) begin
      n_err++; $display("FAIL reset_narrow: got v=%b r=%b imm=%h expected v=0 r=1 imm=0000", n_out_valid, n_in_ready, n_out_imm);
    end
    rst = 1'b0; in_valid = 1'b0; n_in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_accept: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_modes();
    logic [31:0] e [3];
    e[0] = 32'h00008001; e[1] = 32'hFFFF8001; e[2] = 32'h80010000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_chk++; if (out_valid !== 1'b1 || out_imm !== e[i-1]) begin
          n_err++; $display("FAIL modes_%0d: got v=%b imm=%h expected v=1 imm=%h", i-1, out_valid, out_imm, e[i-1]);
        end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL modes_ready_%0d: got %b expected 1", i-1, in_ready); end
      end
      if (i < 3) begin
        in_valid = 1'b1; in_imm = 16'h8001; in_op = 3'(i); in_tag = 5'(i + 4);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL modes_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_branch_and_undefined();
    logic [15:0] imms [6];
    logic [2:0]  ops  [6];
    logic [31:0] e    [6];
    imms[0] = 16'hFFFF; ops[0] = 3'd3; e[0] = EXP_BR_FFFF;
    imms[1] = 16'h0001; ops[1] = 3'd3; e[1] = EXP_BR_0001;
    imms[2] = 16'h1234; ops[2] = 3'd4; e[2] = 32'h0;
    imms[3] = 16'h8765; ops[3] = 3'd5; e[3] = 32'h0;
    imms[4] = 16'hFFFF; ops[4] = 3'd6; e[4] = 32'h0;
    imms[5] = 16'hFFFF; ops[5] = 3'd7; e[5] = 32'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        n_chk++; if (out_valid !== 1'b1 || out_imm !== e[i-1] || out_tag !== 5'(i + 10)) begin
          n_err++; $display("FAIL op_%0d: got v=%b imm=%h tag=%0d expected v=1 imm=%h tag=%0d",
                            ops[i-1], out_valid, out_imm, out_tag, e[i-1], i + 10);
        end
      end
      if (i < 6) begin
        in_valid = 1'b1; in_imm = imms[i]; in_op = ops[i]; in_tag = 5'(i + 11);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h00A1; in_op = 3'd0; in_tag = 5'd1;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
      n_err++; $display("FAIL bp_first: got r=%b v=%b tag=%0d expected r=1 v=1 tag=1", in_ready, out_valid, out_tag);
    end
    in_imm = 16'h00B2; in_tag = 5'd2;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    held = out_imm;
    in_imm = 16'h00C3; in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_imm !== 32'h000000A1 || out_imm !== held) begin
        n_err++; $display("FAIL bp_stall_%0d: got r=%b tag=%0d imm=%h expected r=0 tag=1 imm=000000a1", i, in_ready, out_tag, out_imm);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd2 || out_imm !== 32'h000000B2) begin
      n_err++; $display("FAIL bp_second: got v=%b tag=%0d imm=%h expected v=1 tag=2 imm=000000b2", out_valid, out_tag, out_imm);
    end
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen: got %b expected 1", in_ready); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || out_tag !== 5'd3 || out_imm !== 32'h000000C3) begin
      n_err++; $display("FAIL bp_third: got v=%b tag=%0d imm=%h expected v=1 tag=3 imm=000000c3", out_valid, out_tag, out_imm);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_imm = 16'h0011; in_tag = 5'd4;
    @(negedge clk);
    in_imm = 16'h0022; in_tag = 5'd5;
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_prefill: got in_ready=%b expected 0", in_ready); end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h0033; in_tag = 5'd6;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_accept: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd1; in_imm = 16'hF00D; in_tag = 5'd12;
    @(negedge clk);
    in_imm = 16'hBEEF; in_tag = 5'd13;
    @(negedge clk);
    rst = 1'b1; in_imm = 16'h7777; in_tag = 5'd14;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rstfull_state: got v=%b imm=%h tag=%0d r=%b expected v=0 imm=0 tag=0 r=1",
                        out_valid, out_imm, out_tag, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd2; in_imm = 16'h00AB; in_tag = 5'd7;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b1 || out_imm !== 32'h00AB0000 || out_tag !== 5'd7) begin
      n_err++; $display("FAIL rstfull_accept: got v=%b imm=%h tag=%0d expected v=1 imm=00ab0000 tag=7", out_valid, out_imm, out_tag);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstfull_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_random();
    item_t q[$];
    item_t it;
    bit    exp_v, exp_r;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      n_chk++; if (out_valid !== exp_v || in_ready !== exp_r) begin
        n_err++; $display("FAIL rand_hs_%0d: got v=%b r=%b expected v=%b r=%b", cyc, out_valid, in_ready, exp_v, exp_r);
      end
      if (exp_v) begin
        n_chk++; if (out_imm !== q[0].imm || out_tag !== q[0].tag) begin
          n_err++; $display("FAIL rand_data_%0d: got imm=%h tag=%0d expected imm=%h tag=%0d", cyc, out_imm, out_tag, q[0].imm, q[0].tag);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_imm    = 16'($urandom);
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      if (flush) begin
        q.delete();
      end else begin
        if (exp_v && out_ready) void'(q.pop_front());
        if (in_valid && exp_r) begin
          it.imm = ext_model(int'(in_imm), int'(in_op), 16, 32);
          it.tag = in_tag;
          q.push_back(it);
        end
      end
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_end_flush: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_narrow();
    logic [7:0]  imms [8];
    logic [2:0]  ops  [8];
    logic [15:0] e    [8];
    imms[0] = 8'h80; ops[0] = 3'd1; e[0] = 16'hFF80;
    imms[1] = 8'h12; ops[1] = 3'd2; e[1] = 16'h1200;
    imms[2] = 8'h80; ops[2] = 3'd0; e[2] = 16'h0080;
    imms[3] = 8'hFF; ops[3] = 3'd3; e[3] = EXP_NBR_FF;
    imms[4] = 8'h5A; ops[4] = 3'd4; e[4] = 16'h0000;
    imms[5] = 8'hFF; ops[5] = 3'd5; e[5] = 16'h0000;
    imms[6] = 8'h81; ops[6] = 3'd6; e[6] = 16'h0000;
    imms[7] = 8'h7F; ops[7] = 3'd7; e[7] = 16'h0000;
    n_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        n_chk++; if (n_out_valid !== 1'b1 || n_out_imm !== e[i-1]) begin
          n_err++; $display("FAIL narrow_%0d: got v=%b imm=%h expected v=1 imm=%h", i-1, n_out_valid, n_out_imm, e[i-1]);
        end
      end
      if (i < 8) begin
        n_in_valid = 1'b1; n_in_imm = imms[i]; n_in_op = ops[i]; n_in_tag = 5'(i);
      end else begin
        n_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++; if (n_out_valid !== 1'b0) begin n_err++; $display("FAIL narrow_drain: got v=%b expected 0", n_out_valid); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_branch_and_undefined();
    test_backpressure();
    test_flush();
    test_reset_full();
    test_random();
    test_narrow();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
